imem_load_controller: RTL

IMEM_LOAD_CONTROLLER -- requirements
Module: imem_load_controller

---
 rtl/imem_load_controller.sv | 159 +++++++++++++++
 1 files changed

// File: rtl/imem_load_controller.sv
// UART boot loader for instruction memory: 32-bit little-endian length, payload packed into words, then release the core.
// Optional trailing XOR checksum byte when IMEM_LOAD_CHECKSUM_EN is defined.
module imem_load_controller #(
  parameter int unsigned MAX_BYTES = 4096
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rx_valid,
  input  logic [7:0]  rx_data,
  input  logic        reload_req,
  input  logic [31:0] fetch_addr,
  output logic [31:0] mem_addr,
  output logic        mem_we,
  output logic [31:0] mem_wdata,
  output logic        cpu_run,
  output logic        load_error
);

  localparam logic [2:0] ST_LEN  = 3'd0;
  localparam logic [2:0] ST_DATA = 3'd1;
  localparam logic [2:0] ST_RUN  = 3'd3;
  localparam logic [2:0] ST_ERR  = 3'd4;
`ifdef IMEM_LOAD_CHECKSUM_EN
  localparam logic [2:0] ST_CHK  = 3'd2;
  localparam logic [2:0] ST_DONE = ST_CHK;
`else
  localparam logic [2:0] ST_DONE = ST_RUN;
`endif

  logic [2:0]  state_q, state_d;
  logic [31:0] len_q, len_d;
  logic [31:0] byte_cnt_q, byte_cnt_d;
  logic [29:0] word_idx_q, word_idx_d;
  logic [31:0] pack_q, pack_d;
  logic [31:0] wdata_q, wdata_d;
  logic        we_q, we_d;
  logic        done_q, done_d;
`ifdef IMEM_LOAD_CHECKSUM_EN
  logic [7:0]  xor_q, xor_d;
`endif

  logic [31:0] packed_word;
  logic [31:0] len_next;
  logic [31:0] byte_cnt_inc;
  logic        last_byte;

  assign packed_word  = pack_q | (32'(rx_data) << {byte_cnt_q[1:0], 3'b000});
  assign len_next     = {rx_data, len_q[31:8]};
  assign byte_cnt_inc = byte_cnt_q + 32'd1;
  assign last_byte    = (byte_cnt_inc == len_q);

  always_comb begin
    state_d    = state_q;
    len_d      = len_q;
    byte_cnt_d = byte_cnt_q;
    word_idx_d = word_idx_q;
    pack_d     = pack_q;
    wdata_d    = wdata_q;
    we_d       = 1'b0;
    done_d     = done_q;
`ifdef IMEM_LOAD_CHECKSUM_EN
    xor_d      = xor_q;
`endif
    if (we_q) word_idx_d = word_idx_q + 30'd1;

    case (state_q)
      ST_LEN: begin
        if (rx_valid) begin
          len_d      = len_next;
          byte_cnt_d = byte_cnt_inc;
          if (byte_cnt_q == 32'd3) begin
            byte_cnt_d = '0;
            if (len_next > 32'(MAX_BYTES)) state_d = ST_ERR;
            else if (len_next == 32'd0)    state_d = ST_DONE;
            else                           state_d = ST_DATA;
          end
        end
      end
      ST_DATA: begin
        // done_q marks the write cycle of the final word; leave DATA only after it.
        if (done_q) begin
          done_d  = 1'b0;
          state_d = ST_DONE;
`ifdef IMEM_LOAD_CHECKSUM_EN
          if (rx_valid) state_d = (rx_data == xor_q) ? ST_RUN : ST_ERR;
`endif
        end else if (rx_valid) begin
          byte_cnt_d = byte_cnt_inc;
`ifdef IMEM_LOAD_CHECKSUM_EN
          xor_d      = xor_q ^ rx_data;
`endif
          if (byte_cnt_q[1:0] == 2'd3 || last_byte) begin
            we_d    = 1'b1;
            wdata_d = packed_word;
            pack_d  = '0;
            done_d  = last_byte;
          end else begin
            pack_d  = packed_word;
          end
        end
      end
`ifdef IMEM_LOAD_CHECKSUM_EN
      ST_CHK: begin
        if (rx_valid) state_d = (rx_data == xor_q) ? ST_RUN : ST_ERR;
      end
`endif
      default: ;
    endcase

    if (reload_req) begin
      state_d    = ST_LEN;
      len_d      = '0;
      byte_cnt_d = '0;
      word_idx_d = '0;
      pack_d     = '0;
      we_d       = 1'b0;
      done_d     = 1'b0;
`ifdef IMEM_LOAD_CHECKSUM_EN
      xor_d      = '0;
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_LEN;
      len_q      <= '0;
      byte_cnt_q <= '0;
      word_idx_q <= '0;
      pack_q     <= '0;
      wdata_q    <= '0;
      we_q       <= 1'b0;
      done_q     <= 1'b0;
`ifdef IMEM_LOAD_CHECKSUM_EN
      xor_q      <= '0;
`endif
    end else begin
      state_q    <= state_d;
      len_q      <= len_d;
      byte_cnt_q <= byte_cnt_d;
      word_idx_q <= word_idx_d;
      pack_q     <= pack_d;
      wdata_q    <= wdata_d;
      we_q       <= we_d;
      done_q     <= done_d;
`ifdef IMEM_LOAD_CHECKSUM_EN
      xor_q      <= xor_d;
`endif
    end
  end

  // A reload arriving during a write cycle suppresses that write.
  assign mem_we     = we_q & ~reload_req;
  assign mem_wdata  = wdata_q;
  assign cpu_run    = (state_q == ST_RUN);
  assign load_error = (state_q == ST_ERR);
  assign mem_addr   = cpu_run ? fetch_addr : {word_idx_q, 2'b00};

endmodule
